if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 14 +
 rtl/if_id_storage.sv | 29 ++
 rtl/if_id_buffer.sv | 109 ++++++++++
 tb/tb_if_id_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared processor package: the fetch-entry record carried from IF to ID
// and the instruction decode sees when nothing valid is buffered.
package if_id_buffer_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_storage.sv
// DEPTH-entry register array for buffered fetch entries: one synchronous
// write port, one asynchronous read port. Contents are not reset; validity
// is tracked entirely by the pointer/count control in the parent.
module if_id_storage
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_addr,
    input  fetch_entry_t       wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output fetch_entry_t       rd_data
);

    fetch_entry_t mem [DEPTH];

    // Capture an accepted fetch entry at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a small FIFO of fetch entries between fetch and
// decode. Head fields are read straight from storage (one cycle of latency,
// no bypass) and are forced to a NOP when the buffer is empty so decode
// always sees a benign instruction.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,

    input  logic                       f_valid_i,
    output logic                       f_ready_o,
    input  logic [31:0]                instr_f_i,
    input  logic [31:0]                pc_f_i,
    input  logic [31:0]                pc_plus4_f_i,

    output logic                       d_valid_o,
    input  logic                       d_ready_i,
    output logic [31:0]                instr_d_o,
    output logic [31:0]                pc_d_o,
    output logic [31:0]                pc_plus4_d_o,
    output logic [6:0]                 op_d_o,
    output logic [2:0]                 funct3_d_o,
    output logic [6:0]                 funct7_d_o,
    output logic [4:0]                 rd_d_o,
    output logic [4:0]                 rs1_d_o,
    output logic [4:0]                 rs2_d_o,

    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Ready depends only on occupancy and reset, never on d_ready_i, so a
    // full buffer refuses a push even when decode drains it that cycle.
    assign f_ready_o = (count != FULL_CNT) & ~reset_i;
    assign d_valid_o = (count != '0);
    assign push      = f_valid_i & f_ready_o;
    assign pop       = d_valid_o & d_ready_i;
    assign count_o   = count;

    assign wr_entry.instr    = instr_f_i;
    assign wr_entry.pc       = pc_f_i;
    assign wr_entry.pc_plus4 = pc_plus4_f_i;

    if_id_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk_i),
        .wr_en   (push & ~flush_i),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointer and occupancy control; reset beats flush, flush beats traffic.
    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Present the head entry, or a NOP with zero PCs while empty.
    always_comb begin
        instr_d_o    = NOP_INSTR;
        pc_d_o       = '0;
        pc_plus4_d_o = '0;
        if (d_valid_o) begin
            instr_d_o    = head.instr;
            pc_d_o       = head.pc;
            pc_plus4_d_o = head.pc_plus4;
        end
    end

    assign op_d_o     = instr_d_o[6:0];
    assign rd_d_o     = instr_d_o[11:7];
    assign funct3_d_o = instr_d_o[14:12];
    assign rs1_d_o    = instr_d_o[19:15];
    assign rs2_d_o    = instr_d_o[24:20];
    assign funct7_d_o = instr_d_o[31:25];

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer (DEPTH=2): a hand-computed vector
// table for the directed scenarios, a queue scoreboard checking every
// decode-side pop, a back-to-back wrap sequence and a random stream.
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        f_valid_i = 1'b0;
    logic        f_ready_o;
    logic [31:0] instr_f_i = '0;
    logic [31:0] pc_f_i = '0;
    logic [31:0] pc_plus4_f_i = '0;
    logic        d_valid_o;
    logic        d_ready_i = 1'b0;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic [6:0]  op_d_o;
    logic [2:0]  funct3_d_o;
    logic [6:0]  funct7_d_o;
    logic [4:0]  rd_d_o;
    logic [4:0]  rs1_d_o;
    logic [4:0]  rs2_d_o;
    logic [1:0]  count_o;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .f_valid_i    (f_valid_i),
        .f_ready_o    (f_ready_o),
        .instr_f_i    (instr_f_i),
        .pc_f_i       (pc_f_i),
        .pc_plus4_f_i (pc_plus4_f_i),
        .d_valid_o    (d_valid_o),
        .d_ready_i    (d_ready_i),
        .instr_d_o    (instr_d_o),
        .pc_d_o       (pc_d_o),
        .pc_plus4_d_o (pc_plus4_d_o),
        .op_d_o       (op_d_o),
        .funct3_d_o   (funct3_d_o),
        .funct7_d_o   (funct7_d_o),
        .rd_d_o       (rd_d_o),
        .rs1_d_o      (rs1_d_o),
        .rs2_d_o      (rs2_d_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        fv;
        logic        dr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  cnt;
        logic        dv;
        logic        fr;
        logic [31:0] head;
    } vec_t;

    int           tests_run = 0;
    int           tests_failed = 0;
    int           n_pops = 0;
    fetch_entry_t sb[$];
    vec_t         vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic fl, input logic fv, input logic dr,
                                input logic [31:0] instr, input logic [31:0] pc,
                                input logic [1:0] cnt, input logic dv, input logic fr,
                                input logic [31:0] head);
        vec_t v;
        v.rst = rst; v.fl = fl; v.fv = fv; v.dr = dr;
        v.instr = instr; v.pc = pc;
        v.cnt = cnt; v.dv = dv; v.fr = fr; v.head = head;
        return v;
    endfunction

    // One clock: drive inputs, score a pop against the queue before the
    // edge, update the model at the edge, then check post-edge state.
    task automatic cycle(input logic rst, input logic fl, input logic fv, input logic dr,
                         input logic [31:0] instr, input logic [31:0] pc);
        logic         exp_fr;
        logic         m_push;
        logic         m_pop;
        fetch_entry_t e;
        logic [31:0]  h_instr;
        logic [31:0]  h_pc;
        logic [31:0]  h_pc4;
        reset_i      = rst;
        flush_i      = fl;
        f_valid_i    = fv;
        d_ready_i    = dr;
        instr_f_i    = instr;
        pc_f_i       = pc;
        pc_plus4_f_i = pc + 32'd4;
        #1;
        exp_fr = (sb.size() < DEPTH) && !rst;
        chk("f_ready_pre", {31'd0, f_ready_o}, {31'd0, exp_fr});
        m_push = fv && exp_fr;
        m_pop  = (sb.size() != 0) && dr;
        if (m_pop && !rst && !fl) begin
            e = sb.pop_front();
            n_pops++;
            chk("pop_instr", instr_d_o, e.instr);
            chk("pop_pc", pc_d_o, e.pc);
            chk("pop_pc4", pc_plus4_d_o, e.pc_plus4);
        end
        @(posedge clk_i);
        #1;
        if (rst || fl) begin
            sb.delete();
        end else if (m_push) begin
            e.instr = instr; e.pc = pc; e.pc_plus4 = pc + 32'd4;
            sb.push_back(e);
        end
        h_instr = NOP_INSTR; h_pc = '0; h_pc4 = '0;
        if (sb.size() != 0) begin
            h_instr = sb[0].instr; h_pc = sb[0].pc; h_pc4 = sb[0].pc_plus4;
        end
        chk("count", {30'd0, count_o}, sb.size());
        chk("d_valid", {31'd0, d_valid_o}, {31'd0, (sb.size() != 0)});
        chk("head_instr", instr_d_o, h_instr);
        chk("head_pc", pc_d_o, h_pc);
        chk("head_pc4", pc_plus4_d_o, h_pc4);
        chk("op", {25'd0, op_d_o}, {25'd0, h_instr[6:0]});
        chk("rd", {27'd0, rd_d_o}, {27'd0, h_instr[11:7]});
        chk("funct3", {29'd0, funct3_d_o}, {29'd0, h_instr[14:12]});
        chk("rs1", {27'd0, rs1_d_o}, {27'd0, h_instr[19:15]});
        chk("rs2", {27'd0, rs2_d_o}, {27'd0, h_instr[24:20]});
        chk("funct7", {25'd0, funct7_d_o}, {25'd0, h_instr[31:25]});
    endtask

    initial begin
        int pops_before;
        vec_t v;

        //          rst  fl   fv   dr   instr          pc        cnt dv fr head
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 32'h00000013));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h00000013));
        vecs.push_back(mk(0, 0, 1, 0, 32'h00500093, 32'h0,    1, 1, 1, 32'h00500093));
        vecs.push_back(mk(0, 0, 1, 0, 32'h00a00113, 32'h4,    2, 1, 0, 32'h00500093));
        vecs.push_back(mk(0, 0, 1, 0, 32'h00f00193, 32'h8,    2, 1, 0, 32'h00500093));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        32'h0,    1, 1, 1, 32'h00a00113));
        vecs.push_back(mk(0, 0, 1, 1, 32'h01400213, 32'hc,    1, 1, 1, 32'h01400213));
        vecs.push_back(mk(0, 0, 1, 0, 32'h01900293, 32'h10,   2, 1, 0, 32'h01400213));
        vecs.push_back(mk(0, 0, 1, 1, 32'hdeadbeef, 32'h40,   1, 1, 1, 32'h01900293));
        vecs.push_back(mk(0, 0, 1, 0, 32'h01e00313, 32'h14,   2, 1, 0, 32'h01900293));
        vecs.push_back(mk(0, 1, 1, 1, 32'h02300393, 32'h18,   0, 0, 1, 32'h00000013));
        vecs.push_back(mk(0, 0, 1, 0, 32'h02800413, 32'h1c,   1, 1, 1, 32'h02800413));
        vecs.push_back(mk(0, 0, 1, 0, 32'h02d00493, 32'h20,   2, 1, 0, 32'h02800413));
        vecs.push_back(mk(1, 0, 1, 1, 32'h03200513, 32'h24,   0, 0, 0, 32'h00000013));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h00000013));

        @(negedge clk_i);
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.rst, v.fl, v.fv, v.dr, v.instr, v.pc);
            chk($sformatf("vec%0d_count", i), {30'd0, count_o}, {30'd0, v.cnt});
            chk($sformatf("vec%0d_d_valid", i), {31'd0, d_valid_o}, {31'd0, v.dv});
            chk($sformatf("vec%0d_f_ready", i), {31'd0, f_ready_o}, {31'd0, v.fr});
            chk($sformatf("vec%0d_head", i), instr_d_o, v.head);
        end

        // Directed first-push decode fields: addi x1, x0, 5.
        cycle(0, 0, 1, 0, 32'h00500093, 32'h0);
        chk("first_op", {25'd0, op_d_o}, 32'h13);
        chk("first_rd", {27'd0, rd_d_o}, 32'd1);
        chk("first_count", {30'd0, count_o}, 32'd1);
        cycle(0, 0, 0, 1, 32'h0, 32'h0);

        // Ten back-to-back push/pop cycles across pointer wrap, then drain.
        pops_before = n_pops;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 1, 32'h00000093 + (i << 20), i * 4);
            chk("b2b_f_ready", {31'd0, f_ready_o}, 32'd1);
        end
        cycle(0, 0, 0, 1, 32'h0, 32'h0);
        cycle(0, 0, 0, 1, 32'h0, 32'h0);
        chk("b2b_pops", n_pops - pops_before, 32'd10);
        chk("b2b_empty", {30'd0, count_o}, 32'd0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                  $urandom, i * 4);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(0, 0, 0, 1, 32'h0, 32'h0);
        end
        chk("final_empty", {30'd0, count_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
